// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle execution sequencer between decode and the
// ALU/FPU datapath. Short ALU ops write back on the next cycle. MULT/DIV and
// FPU ops get a start pulse, stall fetch/decode while the unit runs, then raise
// a writeback strobe. Also holds the sticky halt state.
// Optional feature macro: EXEC_SEQ_PERF_EN adds the stall_cycles/long_ops
// performance counters and their output ports.
module exec_sequencer #(
  parameter int         MULT_LAT = 4,
  parameter int         DIV_LAT  = 8,
  parameter int         FPU_LAT  = 6,
  parameter logic [4:0] ALU_MULT = 5'd6,
  parameter logic [4:0] ALU_DIV  = 5'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic       issue_fpu,
  input  logic [4:0] issue_aluop,
  input  logic [3:0] issue_fpuop,
  input  logic       issue_wr_fp,
  input  logic       issue_wr_int,
  input  logic       issue_halt,
  input  logic       flush,
  output logic       alu_start,
  output logic       fpu_start,
  output logic [3:0] fpu_op,
  output logic       stall,
  output logic       wb_valid,
  output logic       wb_int,
  output logic       wb_fp,
  output logic       halted
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] long_ops
`endif
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ?
                           ((MULT_LAT > FPU_LAT) ? MULT_LAT : FPU_LAT) :
                           ((DIV_LAT > FPU_LAT) ? DIV_LAT : FPU_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_WB,
    S_HALT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_m1_q;
  logic [CNT_W-1:0] lat_m1_d;
  logic             lwr_int_q;
  logic             lwr_fp_q;

  logic             issue_ready_q;
  logic             alu_start_q;
  logic             fpu_start_q;
  logic [3:0]       fpu_op_q;
  logic             stall_q;
  logic             wb_valid_q;
  logic             wb_int_q;
  logic             wb_fp_q;
  logic             halted_q;

  logic             issue_fire;
  logic             is_long;

  assign issue_fire = issue_valid && issue_ready_q;
  assign is_long    = issue_fpu || (issue_aluop == ALU_MULT) || (issue_aluop == ALU_DIV);

  // Counter preload (latency minus one) for the op being offered
  always_comb begin
    lat_m1_d = CNT_W'(MULT_LAT - 1);
    if (issue_fpu) begin
      lat_m1_d = CNT_W'(FPU_LAT - 1);
    end else if (issue_aluop == ALU_DIV) begin
      lat_m1_d = CNT_W'(DIV_LAT - 1);
    end
  end

  // Capture latency and write enables of an accepted long op; data only, no reset
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && issue_fire && is_long) begin
      lat_m1_q  <= lat_m1_d;
      lwr_int_q <= issue_wr_int;
      lwr_fp_q  <= issue_wr_fp;
    end
  end

  // Sequencer FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      issue_ready_q <= 1'b1;
      alu_start_q   <= 1'b0;
      fpu_start_q   <= 1'b0;
      fpu_op_q      <= '0;
      stall_q       <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_int_q      <= 1'b0;
      wb_fp_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      fpu_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_int_q    <= 1'b0;
      wb_fp_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // flush squashes whatever is offered this cycle, halt included
          if (issue_fire && !flush) begin
            if (issue_halt) begin
              state_q       <= S_HALT;
              halted_q      <= 1'b1;
              stall_q       <= 1'b1;
              issue_ready_q <= 1'b0;
            end else if (is_long) begin
              state_q       <= S_START;
              alu_start_q   <= !issue_fpu;
              fpu_start_q   <= issue_fpu;
              stall_q       <= 1'b1;
              issue_ready_q <= 1'b0;
              if (issue_fpu) begin
                fpu_op_q <= issue_fpuop;
              end
            end else begin
              wb_valid_q <= 1'b1;
              wb_int_q   <= issue_wr_int;
              wb_fp_q    <= issue_wr_fp;
            end
          end
        end
        S_START: begin
          if (flush) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stall_q       <= 1'b0;
            issue_ready_q <= 1'b1;
          end else begin
            cnt_q <= lat_m1_q;
            if (lat_m1_q == '0) begin
              // unit latency of one: skip BUSY entirely
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              wb_int_q   <= lwr_int_q;
              wb_fp_q    <= lwr_fp_q;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // flush beats the terminal count
          if (flush) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stall_q       <= 1'b0;
            issue_ready_q <= 1'b1;
          end else begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
            if (cnt_q == CNT_W'(1)) begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              wb_int_q   <= lwr_int_q;
              wb_fp_q    <= lwr_fp_q;
            end
          end
        end
        S_WB: begin
          state_q       <= S_IDLE;
          cnt_q         <= '0;
          stall_q       <= 1'b0;
          issue_ready_q <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q       <= S_IDLE;
          cnt_q         <= '0;
          stall_q       <= 1'b0;
          issue_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign issue_ready = issue_ready_q;
  assign alu_start   = alu_start_q;
  assign fpu_start   = fpu_start_q;
  assign fpu_op      = fpu_op_q;
  assign stall       = stall_q;
  assign wb_valid    = wb_valid_q;
  assign wb_int      = wb_int_q;
  assign wb_fp       = wb_fp_q;
  assign halted      = halted_q;

`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] long_ops_q;

  // Stall-cycle and long-op counters; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      long_ops_q     <= '0;
    end else begin
      if (stall_q && state_q != S_HALT) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (state_q == S_START) begin
        long_ops_q <= long_ops_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign long_ops     = long_ops_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against an age-based model of
// the in-flight op.
module tb_exec_sequencer;

  localparam int         MULT_LAT = 4;
  localparam int         DIV_LAT  = 8;
  localparam int         FPU_LAT  = 6;
  localparam logic [4:0] OP_MULT  = 5'd6;
  localparam logic [4:0] OP_DIV   = 5'd7;
  localparam logic [4:0] OP_ADD   = 5'd0;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic       issue_fpu;
  logic [4:0] issue_aluop;
  logic [3:0] issue_fpuop;
  logic       issue_wr_fp;
  logic       issue_wr_int;
  logic       issue_halt;
  logic       flush;
  logic       alu_start;
  logic       fpu_start;
  logic [3:0] fpu_op;
  logic       stall;
  logic       wb_valid;
  logic       wb_int;
  logic       wb_fp;
  logic       halted;

  int errors = 0;
  int checks = 0;

  exec_sequencer #(
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .FPU_LAT(FPU_LAT),
    .ALU_MULT(OP_MULT), .ALU_DIV(OP_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_fpu(issue_fpu), .issue_aluop(issue_aluop), .issue_fpuop(issue_fpuop),
    .issue_wr_fp(issue_wr_fp), .issue_wr_int(issue_wr_int), .issue_halt(issue_halt),
    .flush(flush),
    .alu_start(alu_start), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .stall(stall), .wb_valid(wb_valid), .wb_int(wb_int), .wb_fp(wb_fp),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A long op accepted at cycle c is "age 1" at cycle c+1 (start), stalls
  // through age LAT+1 (writeback), and is gone at age LAT+2.
  bit       m_init = 0;
  bit       m_halt, m_have, m_isfpu, m_wint, m_wfp, m_fseen;
  bit       m_short, m_sint, m_sfp;
  int       m_cyc, m_iss, m_lat;
  logic [3:0] m_fop;
  bit       e_ready, e_alu, e_fpu, e_stall, e_wbv, e_wbi, e_wbf, e_halt, e_fopchk;
  logic [3:0] e_fop;

  always @(posedge clk) begin
    int  age;
    bit  act, is_long_in, fin;
    if (rst) begin
      m_init = 1; m_halt = 0; m_have = 0; m_short = 0; m_fseen = 0;
      m_cyc = 0; m_iss = 0; m_lat = 1;
    end else if (m_init) begin
      age = m_cyc - m_iss;
      act = m_have && age >= 1 && age <= m_lat + 1;
      m_short = 0;
      is_long_in = issue_fpu || issue_aluop == OP_MULT || issue_aluop == OP_DIV;
      if (!m_halt) begin
        if (act) begin
          if (flush) m_have = 0;
        end else if (issue_valid && !flush) begin
          if (issue_halt) begin
            m_halt = 1;
          end else if (is_long_in) begin
            m_have = 1; m_iss = m_cyc; m_isfpu = issue_fpu;
            m_wint = issue_wr_int; m_wfp = issue_wr_fp; m_fop = issue_fpuop;
            m_lat = issue_fpu ? FPU_LAT : (issue_aluop == OP_DIV ? DIV_LAT : MULT_LAT);
            if (issue_fpu) m_fseen = 1;
          end else begin
            m_short = 1; m_sint = issue_wr_int; m_sfp = issue_wr_fp;
          end
        end
      end
      m_cyc++;
    end
    if (m_init) begin
      age = m_cyc - m_iss;
      act = m_have && age >= 1 && age <= m_lat + 1;
      fin = act && age == m_lat + 1;
      e_ready  = !m_halt && !act;
      e_alu    = act && age == 1 && !m_isfpu;
      e_fpu    = act && age == 1 && m_isfpu;
      e_stall  = m_halt || act;
      e_wbv    = fin || m_short;
      e_wbi    = fin ? m_wint : (m_short ? m_sint : 1'b0);
      e_wbf    = fin ? m_wfp  : (m_short ? m_sfp  : 1'b0);
      e_halt   = m_halt;
      e_fopchk = (act && m_isfpu) || !m_fseen;
      e_fop    = (act && m_isfpu) ? m_fop : 4'h0;
    end
  end

  // Single compare process against the model, every cycle once it is seeded
  always @(negedge clk) begin
    if (m_init) begin
      chk("issue_ready", issue_ready, e_ready);
      chk("alu_start", alu_start, e_alu);
      chk("fpu_start", fpu_start, e_fpu);
      chk("stall", stall, e_stall);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_int", wb_int, e_wbi);
      chk("wb_fp", wb_fp, e_wbf);
      chk("halted", halted, e_halt);
      if (e_fopchk) chk("fpu_op", fpu_op, e_fop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    issue_valid = 0; issue_fpu = 0; issue_aluop = OP_ADD; issue_fpuop = 4'h0;
    issue_wr_fp = 0; issue_wr_int = 0; issue_halt = 0; flush = 0;
  endtask

  task automatic drive(input logic fpu, input logic [4:0] aop, input logic [3:0] fop,
                       input logic wint, input logic wfp);
    issue_valid = 1; issue_fpu = fpu; issue_aluop = aop; issue_fpuop = fop;
    issue_wr_int = wint; issue_wr_fp = wfp; issue_halt = 0; flush = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (3) tick();
    chk("rst_ready", issue_ready, 1); chk("rst_stall", stall, 0);
    chk("rst_wb", wb_valid, 0); chk("rst_halted", halted, 0);
    chk("rst_fpu_op", fpu_op, 0); chk("rst_alu_start", alu_start, 0);
    rst = 0;

    // 1) short ADD
    drive(0, OP_ADD, 4'h0, 1, 0);
    tick(); clr();
    chk("t1_wb_valid", wb_valid, 1); chk("t1_wb_int", wb_int, 1); chk("t1_stall", stall, 0);
    tick();
    chk("t1_wb_clear", wb_valid, 0); chk("t1_stall2", stall, 0);

    // 2) MULT, latency 4
    drive(0, OP_MULT, 4'h0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(); if (k == 1) clr();
      chk("t2_alu_start", alu_start, k == 1);
      chk("t2_stall", stall, k <= 5);
      chk("t2_wb_valid", wb_valid, k == 5);
      chk("t2_ready", issue_ready, k == 6);
    end

    // 3) FPU op 3, latency 6
    drive(1, OP_ADD, 4'h3, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(); if (k == 1) clr();
      chk("t3_fpu_start", fpu_start, k == 1);
      if (k <= 7) chk("t3_fpu_op", fpu_op, 4'h3);
      chk("t3_wb_valid", wb_valid, k == 7);
      chk("t3_wb_fp", wb_fp, k == 7);
      chk("t3_stall", stall, k <= 7);
    end

    // 4) DIV flushed at cycle 4, ADD at cycle 5
    drive(0, OP_DIV, 4'h0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(); if (k == 1) clr();
      chk("t4_wb_valid", wb_valid, k == 6);
      if (k == 4) begin chk("t4_stall", stall, 1); flush = 1; end
      if (k == 5) begin
        chk("t4_ready", issue_ready, 1); chk("t4_stall_idle", stall, 0);
        drive(0, OP_ADD, 4'h0, 1, 0);
      end
      if (k == 6) begin clr(); chk("t4_wb_int", wb_int, 1); end
    end

    // 5) halt is sticky under continuous issue traffic
    issue_valid = 1; issue_halt = 1;
    tick();
    issue_halt = 0;
    chk("t5_halted", halted, 1);
    for (int k = 0; k < 100; k++) begin
      issue_valid = 1; issue_fpu = 1'($urandom_range(0, 1));
      issue_aluop = 5'($urandom_range(0, 31));
      tick();
      chk("t5_halted_hold", halted, 1); chk("t5_ready", issue_ready, 0);
    end
    rst = 1; clr();
    tick();
    chk("t5_rst_halted", halted, 0); chk("t5_rst_ready", issue_ready, 1);
    rst = 0;

    // 6) reset in the middle of a MULT
    drive(0, OP_MULT, 4'h0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); if (k == 1) clr();
      if (k == 3) rst = 1;
    end
    chk("t6_ready", issue_ready, 1); chk("t6_stall", stall, 0);
    chk("t6_wb", wb_valid, 0); chk("t6_alu_start", alu_start, 0);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); chk("t6_no_wb", wb_valid, 0);
    end

    // Randomized traffic, checked by the per-cycle compare process
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 99) < 8);
      issue_valid = ($urandom_range(0, 99) < 70);
      issue_fpu   = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 3))
        0:       issue_aluop = OP_MULT;
        1:       issue_aluop = OP_DIV;
        default: issue_aluop = 5'($urandom_range(0, 31));
      endcase
      issue_fpuop  = 4'($urandom_range(0, 15));
      issue_wr_int = 1'($urandom_range(0, 1));
      issue_wr_fp  = 1'($urandom_range(0, 1));
      issue_halt   = ($urandom_range(0, 99) < 2);
      tick();
    end
    clr(); rst = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
